// File: rtl/gb_cart_pkg.sv
// gb_cart_pkg: state encoding, per-state quarter lengths and
// well-known cartridge addresses for gb_cart_bus_master.
package gb_cart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_CSEL,
    S_WR,
    S_WREC,
    S_END,
    S_RWAIT,
    S_RHOLD
  } state_e;

  localparam int ADDR_Q  = 1;
  localparam int CSEL_Q  = 2;
  localparam int WR_Q    = 3;
  localparam int WREC_Q  = 1;
  localparam int END_Q   = 1;
  localparam int RWAIT_Q = 2;
  localparam int RHOLD_Q = 3;

  localparam logic [15:0] ROM_BANK_REG = 16'h2000;
  localparam logic [15:0] RAM_BANK_REG = 16'h4000;
  localparam logic [15:0] RAM_BASE     = 16'hA000;

  function automatic int state_quarters(state_e s);
    int q;
    q = 1;
    case (s)
      S_ADDR:  q = ADDR_Q;
      S_CSEL:  q = CSEL_Q;
      S_WR:    q = WR_Q;
      S_WREC:  q = WREC_Q;
      S_END:   q = END_Q;
      S_RWAIT: q = RWAIT_Q;
      S_RHOLD: q = RHOLD_Q;
      default: q = 1;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/gb_cart_clkgen.sv
// gb_cart_clkgen: free-running PHI divider and the cartridge
// reset hold counter that releases cart_nRST after RST_HOLD cycles.
module gb_cart_clkgen #(
  parameter int CLK_HALF = 50,
  parameter int RST_HOLD = 1000
) (
  input  logic sys_clock,
  input  logic reset,
  output logic cart_clk,
  output logic cart_nrst
);

  localparam int HW = $clog2(CLK_HALF + 1);
  localparam int RW = $clog2(RST_HOLD + 1);

  logic [HW-1:0] half_q, half_d;
  logic [RW-1:0] hold_q, hold_d;
  logic          clk_q, clk_d;
  logic          nrst_q, nrst_d;

  always_comb begin
    half_d = half_q + HW'(1);
    clk_d  = clk_q;
    if (half_q == HW'(CLK_HALF - 1)) begin
      half_d = '0;
      clk_d  = ~clk_q;
    end
    hold_d = hold_q;
    nrst_d = nrst_q;
    if (!nrst_q) begin
      hold_d = hold_q + RW'(1);
      if (hold_q == RW'(RST_HOLD - 1)) nrst_d = 1'b1;
    end
  end

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      half_q <= '0;
      clk_q  <= 1'b0;
      hold_q <= '0;
      nrst_q <= 1'b0;
    end else begin
      half_q <= half_d;
      clk_q  <= clk_d;
      hold_q <= hold_d;
      nrst_q <= nrst_d;
    end
  end

  assign cart_clk  = clk_q;
  assign cart_nrst = nrst_q;

endmodule

// File: rtl/gb_cart_bus_master.sv
// gb_cart_bus_master: host-side Game Boy cartridge bus initiator.
// Define GB_CART_DATA_SYNC_EN to route cart_d_i through a 2-flop synchroniser.
module gb_cart_bus_master
  import gb_cart_pkg::*;
#(
  parameter int Q_CYC    = 13,
  parameter int CLK_HALF = 50,
  parameter int RST_HOLD = 1000
) (
  input  logic        sys_clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_ram,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        busy,
  output logic        cart_CLK,
  output logic [15:0] cart_a,
  output logic [7:0]  cart_d_o,
  output logic        cart_d_oe,
  input  logic [7:0]  cart_d_i,
  output logic        cart_nRD,
  output logic        cart_nWR,
  output logic        cart_nCS,
  output logic        cart_nRST
);

  localparam int CW = $clog2(3 * Q_CYC + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          write_q, write_d;
  logic          ram_q, ram_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_rdata_q, rsp_rdata_d;
  logic          accept, last, cap;
  logic [7:0]    cap_data;

  gb_cart_clkgen #(
    .CLK_HALF (CLK_HALF),
    .RST_HOLD (RST_HOLD)
  ) u_clkgen (
    .sys_clock (sys_clock),
    .reset     (reset),
    .cart_clk  (cart_CLK),
    .cart_nrst (cart_nRST)
  );

  assign req_ready = (state_q == S_IDLE) && cart_nRST;
  assign busy      = (state_q != S_IDLE);
  assign accept    = req_valid && req_ready;
  assign last      = (cnt_q == CW'(state_quarters(state_q) * Q_CYC - 1));

`ifdef GB_CART_DATA_SYNC_EN
  logic [7:0] sync1_q, sync2_q;

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= cart_d_i;
      sync2_q <= sync1_q;
    end
  end

  // Late capture leaves the synchroniser a full quarter to settle.
  assign cap      = (state_q == S_RHOLD) && (cnt_q == CW'(Q_CYC - 1));
  assign cap_data = sync2_q;
`else
  assign cap      = (state_q == S_RWAIT) && last;
  assign cap_data = cart_d_i;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    ram_d       = ram_q;
    rsp_valid_d = (state_q == S_RHOLD) && last;
    rsp_rdata_d = cap ? cap_data : rsp_rdata_q;
    if (state_q == S_IDLE) begin
      cnt_d = '0;
      if (accept) begin
        state_d = S_ADDR;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        write_d = req_write;
        ram_d   = req_ram;
      end
    end else if (last) begin
      cnt_d = '0;
      unique case (state_q)
        S_ADDR:  state_d = S_CSEL;
        S_CSEL:  state_d = write_q ? S_WR : S_RWAIT;
        S_WR:    state_d = S_WREC;
        S_WREC:  state_d = S_END;
        S_RWAIT: state_d = S_RHOLD;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cart_nRD  = 1'b0;
    cart_nWR  = 1'b1;
    cart_nCS  = 1'b1;
    cart_d_oe = 1'b0;
    unique case (state_q)
      S_ADDR: begin
        cart_nRD  = write_q;
        cart_d_oe = write_q;
      end
      S_CSEL: begin
        cart_nRD  = write_q;
        cart_d_oe = write_q;
        cart_nCS  = ~ram_q;
      end
      S_WR: begin
        cart_nRD  = 1'b1;
        cart_d_oe = 1'b1;
        cart_nCS  = ~ram_q;
        cart_nWR  = 1'b0;
      end
      S_WREC: begin
        cart_nRD  = 1'b1;
        cart_d_oe = 1'b1;
        cart_nCS  = ~ram_q;
      end
      S_RWAIT: cart_nCS = ~ram_q;
      S_RHOLD: cart_nCS = last | ~ram_q;
      default: ;
    endcase
  end

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      ram_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      ram_q       <= ram_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign cart_a    = addr_q;
  assign cart_d_o  = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_gb_cart_bus_master.sv
// tb_gb_cart_bus_master: scoreboard bench with a bus-level cartridge
// model and a transaction-level reference model.
module tb_gb_cart_bus_master;

  logic        sys_clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic        req_ram = 1'b0;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        busy;
  logic        cart_CLK;
  logic [15:0] cart_a;
  logic [7:0]  cart_d_o;
  logic        cart_d_oe;
  logic [7:0]  cart_d_i;
  logic        cart_nRD;
  logic        cart_nWR;
  logic        cart_nCS;
  logic        cart_nRST;

  gb_cart_bus_master dut (
    .sys_clock (sys_clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_ram   (req_ram),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .cart_CLK  (cart_CLK),
    .cart_a    (cart_a),
    .cart_d_o  (cart_d_o),
    .cart_d_oe (cart_d_oe),
    .cart_d_i  (cart_d_i),
    .cart_nRD  (cart_nRD),
    .cart_nWR  (cart_nWR),
    .cart_nCS  (cart_nCS),
    .cart_nRST (cart_nRST)
  );

  always #5 sys_clock = ~sys_clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge sys_clock) cyc <= cyc + 1;

  // Cartridge model: answers the bus pins, latches writes on nWR rise.
  logic [7:0] cmem [8192];
  logic [7:0] cbank = 8'h01;

  always_comb begin
    cart_d_i = 8'hFF;
    if (!cart_nCS) cart_d_i = cmem[cart_a[12:0]];
    else if (cart_a < 16'h4000) cart_d_i = cart_a[7:0] ^ cart_a[15:8];
    else if (cart_a < 16'h8000) cart_d_i = cbank ^ cart_a[7:0];
  end

  always @(posedge cart_nWR) begin
    if (!reset && cart_d_oe) begin
      if (!cart_nCS) cmem[cart_a[12:0]] = cart_d_o;
      else if (cart_a[15:13] == 3'b001) cbank = cart_d_o;
    end
  end

  // Reference model: transaction-level cartridge contents.
  logic [7:0] rmem [8192];
  logic [7:0] rbank = 8'h01;
  logic [7:0] exp_q [$];
  int         acc_cyc [$];

  function automatic logic [7:0] ref_read(logic [15:0] a, logic ram);
    if (ram) return rmem[a[12:0]];
    if (a < 16'h4000) return a[7:0] ^ a[15:8];
    if (a < 16'h8000) return rbank ^ a[7:0];
    return 8'hFF;
  endfunction

  task automatic ref_write(logic [15:0] a, logic ram, logic [7:0] d);
    if (ram) rmem[a[12:0]] = d;
    else if (a >= 16'h2000 && a < 16'h4000) rbank = d;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge sys_clock) begin
    if (!reset && req_valid && req_ready) acc_cyc.push_back(cyc);
  end

  always @(negedge sys_clock) begin
    if (!reset && rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp act=%0h exp=none cyc=%0d",
                 rsp_rdata, cyc);
      end else begin
        chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic send(bit w, bit ram, logic [15:0] a, logic [7:0] d,
                      bit keep);
    int n;
    n = 0;
    req_write = w;
    req_ram   = ram;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    while (!req_ready && n < 1000) begin
      @(negedge sys_clock);
      n++;
    end
    chk("accept_wait", 32'(n < 1000), 32'd1);
    if (n >= 1000) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge sys_clock);
    if (w) ref_write(a, ram, d);
    else exp_q.push_back(ref_read(a, ram));
    #1;
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_nrst(output int n, output int early);
    n = 0;
    early = 0;
    while (n < 3000) begin
      @(posedge sys_clock);
      n++;
      @(negedge sys_clock);
      if (cart_nRST) break;
      if (req_ready) early++;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 500) begin
      @(negedge sys_clock);
      n++;
    end
    chk("idle_wait", 32'(n < 500), 32'd1);
  endtask

  initial begin
    int n, early, r0, r1;
    logic prev;
    logic [31:0] r;

    for (int i = 0; i < 8192; i++) begin
      r = $urandom;
      cmem[i] = r[7:0];
      rmem[i] = r[7:0];
    end
    cmem[16] = 8'hF1;
    rmem[16] = 8'hF1;

    repeat (3) @(negedge sys_clock);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_clk", 32'(cart_CLK), 0);
    chk("rst_a", 32'(cart_a), 0);
    chk("rst_d_o", 32'(cart_d_o), 0);
    chk("rst_oe", 32'(cart_d_oe), 0);
    chk("rst_nrd", 32'(cart_nRD), 0);
    chk("rst_nwr", 32'(cart_nWR), 1);
    chk("rst_ncs", 32'(cart_nCS), 1);
    chk("rst_nrst", 32'(cart_nRST), 0);

    reset = 1'b0;
    wait_nrst(n, early);
    chk("nrst_hold", 32'(n), 32'd1000);
    chk("ready_early", 32'(early), 0);
    chk("ready_with_nrst", 32'(req_ready), 1);

    r0 = -1;
    r1 = -1;
    prev = cart_CLK;
    for (int i = 0; i < 300 && r1 < 0; i++) begin
      @(negedge sys_clock);
      if (cart_CLK && !prev) begin
        if (r0 < 0) r0 = cyc;
        else r1 = cyc;
      end
      prev = cart_CLK;
    end
    chk("clk_period", 32'(r1 - r0), 32'd100);

    send(1'b1, 1'b0, 16'h2000, 8'h05, 1'b0);
    for (int c = 1; c <= 105; c++) begin
      @(negedge sys_clock);
      chk("w_nrd", 32'(cart_nRD), 32'(c <= 91));
      chk("w_nwr", 32'(cart_nWR), 32'(!(c >= 40 && c <= 78)));
      chk("w_oe", 32'(cart_d_oe), 32'(c <= 91));
      chk("w_ncs", 32'(cart_nCS), 1);
      chk("w_ready", 32'(req_ready), 32'(c == 105));
      chk("w_busy", 32'(busy), 32'(c != 105));
      if (c == 1) begin
        chk("w_addr", 32'(cart_a), 32'h2000);
        chk("w_dout", 32'(cart_d_o), 32'h05);
      end
    end
    chk("cart_bank", 32'(cbank), 32'h05);

    send(1'b0, 1'b1, 16'hA010, 8'h00, 1'b0);
    for (int c = 1; c <= 105; c++) begin
      @(negedge sys_clock);
      chk("r_ncs", 32'(cart_nCS), 32'(!(c >= 14 && c <= 103)));
      chk("r_nrd", 32'(cart_nRD), 0);
      chk("r_nwr", 32'(cart_nWR), 1);
      chk("r_oe", 32'(cart_d_oe), 0);
      chk("r_valid", 32'(rsp_valid), 32'(c == 105));
    end

    send(1'b0, 1'b0, 16'h6000, 8'h00, 1'b0);
    for (int c = 1; c <= 105; c++) begin
      @(negedge sys_clock);
      chk("rb_ncs", 32'(cart_nCS), 1);
      chk("rb_valid", 32'(rsp_valid), 32'(c == 105));
    end

    send(1'b1, 1'b0, 16'h0000, 8'h0A, 1'b0);
    repeat (49) @(negedge sys_clock);
    chk("mid_nwr", 32'(cart_nWR), 0);
    reset = 1'b1;
    #1;
    chk("mr_nwr", 32'(cart_nWR), 1);
    chk("mr_oe", 32'(cart_d_oe), 0);
    chk("mr_nrst", 32'(cart_nRST), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_ready", 32'(req_ready), 0);
    chk("mr_nrd", 32'(cart_nRD), 0);
    chk("mr_ncs", 32'(cart_nCS), 1);
    @(negedge sys_clock);
    reset = 1'b0;
    wait_nrst(n, early);
    chk("nrst_hold2", 32'(n), 32'd1000);

    acc_cyc.delete();
    send(1'b1, 1'b1, 16'hA123, 8'h5A, 1'b1);
    send(1'b0, 1'b1, 16'hA123, 8'h00, 1'b1);
    send(1'b0, 1'b0, 16'h1234, 8'h00, 1'b0);
    wait_idle();
    repeat (3) @(negedge sys_clock);
    chk("b2b_accepts", 32'(acc_cyc.size()), 3);
    if (acc_cyc.size() == 3) begin
      chk("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd105);
      chk("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd105);
    end

    for (int i = 0; i < 20; i++) begin
      r = $urandom;
      send(r[31], r[30], r[15:0], r[23:16], 1'b0);
    end
    wait_idle();
    repeat (4) @(negedge sys_clock);
    chk("sb_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gb_cart_bus_master.md
Name: gb_cart_bus_master

Overview:
- Host-side initiator for the Game Boy cartridge bus; the counterpart of the cartridge-side ag32gbd_ip.
- Converts single-beat read/write requests from the AG32 fabric into timed cart bus cycles covering ROM reads, MBC register writes, and RAM or camera register accesses.
- Generates the free-running cart_CLK (PHI) and cart_nRST.
- Serves as the hardware replacement for bench-driven bus tasks and as a cart reader on host-side boards.

Parameters:
- Q_CYC, 13: sys_clock cycles per bus quarter-slot (about 125 ns at 100 MHz).
- CLK_HALF, 50: sys_clock cycles per cart_CLK half-period (1 MHz at 100 MHz).
- RST_HOLD, 1000: sys_clock cycles cart_nRST is held low after reset deasserts.

Ports:
- sys_clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted on the cycle where req_valid && req_ready
- req_write  in  1  1 = write, 0 = read
- req_ram  in  1  1 = assert cart_nCS (A000-BFFF space), 0 = ROM/MBC space
- req_addr  in  16  bus address
- req_wdata  in  8  write data
- rsp_valid  out  1  one-cycle pulse when a read completes
- rsp_rdata  out  8  read data, held until the next read completes
- busy  out  1  transaction in progress
- cart_CLK  out  1  PHI clock
- cart_a  out  16  address
- cart_d_o  out  8  data out
- cart_d_oe  out  1  data output enable (the top level builds the tristate)
- cart_d_i  in  8  data in
- cart_nRD  out  1  read strobe, active low
- cart_nWR  out  1  write strobe, active low
- cart_nCS  out  1  RAM chip select, active low
- cart_nRST  out  1  cartridge reset, active low

Behaviour:
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_rdata=00, busy=0.
  - cart_CLK=0, cart_a=0000, cart_d_o=00, cart_d_oe=0.
  - cart_nRD=0, cart_nWR=1, cart_nCS=1, cart_nRST=0.
- Reset mid-transaction forces all of the above immediately. The in-flight request is dropped and no rsp_valid is produced.
- cart_nRST: stays 0 while reset is high and for RST_HOLD cycles afterwards, then goes to 1 and stays there. req_ready=0 until cart_nRST=1.
- cart_CLK: free-running. Toggles every CLK_HALF cycles. Not aligned to transactions.
- req_ready = (state==IDLE) && cart_nRST.
- On accept, latch addr, wdata, write and ram. Inputs are don't-care after accept.
- busy = (state != IDLE).
- A quarter counter counts 0..Q_CYC-1. State advances when the count reaches the state's length in quarters × Q_CYC − 1.
- FSM states, lengths in quarters, and outputs:
  - IDLE: nRD=0, nWR=1, nCS=1, oe=0. cart_a holds the last address.
  - ADDR (1): nRD=1, cart_a=addr. For writes, oe=1 and cart_d_o=wdata.
  - CSEL (2): nCS=~ram.
  - Write path:
    - WR (3): nWR=0.
    - WREC (1): nWR=1.
    - END (1): nCS=1, nRD=0, oe=0. Then IDLE.
  - Read path:
    - In ADDR, nRD is instead 0 and stays 0 for the whole read.
    - RWAIT (2): on the last cycle, capture cart_d_i into rsp_rdata.
    - RHOLD (3): at the final cycle, nCS=1.
    - Then IDLE with rsp_valid=1 for 1 cycle.
- Every transaction is 8 quarters (104 cycles at the default Q_CYC).
- req_ready re-asserts on the first IDLE cycle. Back-to-back requests therefore have at least 1 idle cycle between them.
- The block performs no address-range checking: req_ram with any address asserts nCS. A write with addr[15]=0 is an MBC register write.
- rsp_valid and req_ready can be high in the same cycle. A new request may be accepted on the same cycle rsp_valid pulses.

Optional Feature:
- Macro: GB_CART_DATA_SYNC_EN.
- When defined:
  - cart_d_i passes through a 2-flop synchroniser.
  - The capture point moves to the end of the first RHOLD quarter.
  - Total transaction length is unchanged.
- When undefined, cart_d_i is sampled directly at the end of RWAIT.

Decomposition:
- Shared package gb_cart_pkg holds:
  - the state enum;
  - quarter counts per state as localparams (ADDR_Q=1, CSEL_Q=2, WR_Q=3, WREC_Q=1, END_Q=1, RWAIT_Q=2, RHOLD_Q=3);
  - address constants for ROM_BANK_REG=2000, RAM_BANK_REG=4000 and RAM_BASE=A000.
- One natural sub-module is gb_cart_clkgen: the cart_CLK divider plus the cart_nRST hold counter.

Test Plan:
- After reset release → cart_nRST=0 for exactly 1000 cycles, then 1. req_ready rises on the same cycle. cart_CLK has a 100-cycle period.
- Write {addr=2000, data=05, ram=0}:
  - nRD high from cycle 1; nWR low on cycles 40..78; oe high on cycles 1..91; nCS stays 1.
  - req_ready returns at cycle 105.
  - The cartridge model's ROM bank register = 05.
- Read {addr=A010, ram=1} with the model driving F1 → nCS low on cycles 14..103. rsp_valid pulses once with rsp_rdata=F1. nWR stays 1 and oe stays 0 throughout.
- Read {addr=6000, ram=0} after the bank-5 write → rsp_rdata=05 and nCS stays 1.
- Assert reset during the WR state → nWR=1, oe=0, nRST=0 immediately. No rsp_valid follows.
- Hold req_valid high continuously for three mixed requests → each is accepted exactly once, with a 1-cycle gap between accepts. Repeat with GB_CART_DATA_SYNC_EN defined → identical rsp_rdata values.
